// File: rtl/aes128_dsp_ctrl.sv
// aes128_dsp_ctrl: round sequencer for an iterative AES-128 datapath
module aes128_dsp_ctrl #(
  parameter int NR      = 10,
  parameter int RND_LAT = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       ABORT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       SEL_IN,
  output logic       DP_EN,
  output logic [3:0] ROUND_IDX,
  output logic [2:0] PHASE,
  output logic       LAST_ROUND,
  output logic [7:0] RCON,
  output logic       BUSY
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0][7:0] RCON_TAB = {8'h00, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80,
                                           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
  state_t     state, state_n;
  logic [3:0] round, round_n;
  logic [2:0] phase, phase_n;
  logic       run, wrap, fin;
  // Output decode: only IN_READY/SEL_IN (and DP_EN through SEL_IN) see the inputs
  always_comb begin
    run        = state == RUN;
    wrap       = phase == 3'(RND_LAT - 1);
    fin        = round == 4'(NR);
    IN_READY   = state == IDLE && RSTN && !ABORT;
    SEL_IN     = IN_VALID && IN_READY;
    DP_EN      = SEL_IN || run;
    OUT_VALID  = state == DONE;
    BUSY       = state != IDLE;
    LAST_ROUND = run && fin;
    ROUND_IDX  = round;
    PHASE      = phase;
    RCON       = run ? RCON_TAB[round] : 8'h00;
  end
  // Next state: abort wins, then accept, round stepping, and the output handshake
  always_comb begin
    state_n = state;
    round_n = round;
    phase_n = phase;
    if (ABORT) begin
      state_n = IDLE;
      round_n = '0;
      phase_n = '0;
    end else if (state == IDLE && IN_VALID) begin
      state_n = RUN;
      round_n = 4'd1;
      phase_n = '0;
    end else if (run) begin
      phase_n = wrap ? 3'd0 : phase + 3'd1;
      if (wrap) begin
        state_n = fin ? DONE : RUN;
        round_n = fin ? round : round + 4'd1;
      end
    end else if (state == DONE && OUT_READY) begin
      state_n = IDLE;
      round_n = '0;
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      round <= '0;
      phase <= '0;
    end else begin
      state <= state_n;
      round <= round_n;
      phase <= phase_n;
    end
  end
endmodule

// File: tb/tb_aes128_dsp_ctrl.sv
// tb_aes128_dsp_ctrl: scoreboard bench for the default and NR=14/RND_LAT=1 configurations
module tb_aes128_dsp_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", name, g, $time, act, exp);
    end
  endtask

  // Round constant as repeated doubling in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] rc(input int r);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 1; i < r; i++) x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    return x;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NR = g ? 14 : 10;
    localparam int L  = g ? 1 : 4;
    logic       rstn, in_valid, abort, out_ready;
    logic       in_ready, out_valid, sel_in, dp_en, last_round, busy;
    logic [3:0] round_idx;
    logic [2:0] phase;
    logic [7:0] rcon;
    int         q[$];
    int         cyc = 0;
    bit         m_busy = 0;
    int         m_acc = 0;
    bit         fin = 0;
    logic       ov_prev = 1'b0;

    aes128_dsp_ctrl #(.NR(NR), .RND_LAT(L)) dut (
      .CLK(CLK), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready), .ABORT(abort),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .SEL_IN(sel_in), .DP_EN(dp_en),
      .ROUND_IDX(round_idx), .PHASE(phase), .LAST_ROUND(last_round), .RCON(rcon), .BUSY(busy)
    );

    // Monitor: each newly presented result must match the oldest expected completion cycle
    always @(negedge CLK) begin
      if (out_valid === 1'b1 && ov_prev !== 1'b1)
        chk("out_cycle", g, cyc, q.size() ? q.pop_front() : -1);
      ov_prev <= out_valid;
    end

    // Driver plus timing model: a block occupies NR*L run cycles after its accept cycle, then waits for the sink
    initial begin
      rstn = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
      @(posedge CLK);
      cyc = 1;
      for (int s = 0; s < 3600; s++) begin
        int t, er;
        bit run, dn, acc, hs;
        @(negedge CLK);
        t   = cyc - m_acc;
        run = m_busy && t <= NR * L;
        dn  = m_busy && t > NR * L;
        er  = run ? (t - 1) / L + 1 : dn ? NR : 0;
        chk("round_idx", g, round_idx, er);
        chk("last_round", g, last_round, run && er == NR);
        chk("out_valid", g, out_valid, dn);
        chk("busy", g, busy, m_busy);
        if (!dn) begin
          chk("phase", g, phase, run ? (t - 1) % L : 0);
          chk("rcon", g, rcon, run ? rc(er) : 0);
        end
        if (s < 200) begin
          rstn = 1'b1; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        end else if (s < 500) begin
          rstn = 1'b1; abort = run && t == 4 * L + 3;
          in_valid = 1'($urandom % 2); out_ready = 1'($urandom % 2);
        end else if (s < 800) begin
          rstn = !(dn && t == NR * L + 3); abort = 1'b0;
          in_valid = 1'($urandom % 2); out_ready = 1'b0;
        end else if (s < 3500) begin
          rstn = $urandom % 150 != 0; abort = $urandom % 120 == 0;
          in_valid = $urandom % 3 != 0; out_ready = $urandom % 3 != 0;
        end else begin
          rstn = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        end
        #1;
        acc = rstn && !abort && !m_busy && in_valid;
        hs  = dn && out_ready;
        chk("in_ready", g, in_ready, rstn && !abort && !m_busy);
        chk("sel_in", g, sel_in, acc);
        chk("dp_en", g, dp_en, acc || run);
        @(posedge CLK);
        cyc++;
        if (!rstn || abort) begin
          if (m_busy) q.delete();
          m_busy = 0;
        end else if (acc) begin
          m_busy = 1;
          m_acc  = cyc - 1;
          q.push_back(cyc + NR * L);
        end else if (hs) begin
          m_busy = 0;
        end
      end
      @(negedge CLK);
      chk("drained", g, q.size(), 0);
      fin = 1;
    end
  end

  initial begin
    wait (u[0].fin && u[1].fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
